// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - multi-channel clock-gating controller with idle hysteresis, wake latency and bypass
//
// Purpose: derives NUM_CH gated clocks from clk. Each channel runs an independent
// ON/OFF/WAKE state machine driven by its activity request. A channel that sees
// IDLE_CYCLES consecutive idle cycles loses its clock. Any later request restarts
// the clock, and ch_ready follows WAKE_CYCLES cycles after the restart.
//
// Ports:
//   clk          core clock; all state updates on posedge, enable latch on negedge
//   rst          synchronous active-high reset; all channels return to ON
//   ch_busy      per-channel activity request
//   force_on     per-channel override; keeps the channel ON and holds the idle count at zero
//   gate_bypass  forces every gated clock to follow clk and every ch_ready to 1
//   clk_gated    gated clocks, one per channel
//   ch_ready     channel clock is running and stable
//   ch_on        channel FSM is in ON or WAKE

module clk_gate_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_busy,
  input  logic [NUM_CH-1:0] force_on,
  input  logic              gate_bypass,
  output logic [NUM_CH-1:0] clk_gated,
  output logic [NUM_CH-1:0] ch_ready,
  output logic [NUM_CH-1:0] ch_on
);

  localparam int             IW        = $clog2(IDLE_CYCLES + 1);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(IDLE_CYCLES - 1);
  // Only meaningful when WAKE_CYCLES > 0; with zero wake cycles WAKE is never entered.
  localparam logic [3:0]     WAKE_LAST = (WAKE_CYCLES == 0) ? 4'd0 : 4'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ON   = 2'd0,
    ST_OFF  = 2'd1,
    ST_WAKE = 2'd2
  } state_t;

  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] en_q;
  logic [NUM_CH-1:0] on_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idle_cnt;
    logic [IW-1:0] idle_cnt_nxt;
    logic [3:0]    wake_cnt;
    logic [3:0]    wake_cnt_nxt;
    logic          active;

    // force_on carries the same weight as a real request.
    assign active = ch_busy[g] | force_on[g];

    always_ff @(posedge clk) begin
      if (rst) begin
        state    <= ST_ON;
        idle_cnt <= '0;
        wake_cnt <= '0;
      end else begin
        state    <= state_nxt;
        idle_cnt <= idle_cnt_nxt;
        wake_cnt <= wake_cnt_nxt;
      end
    end

    always_comb begin
      state_nxt    = state;
      idle_cnt_nxt = idle_cnt;
      wake_cnt_nxt = wake_cnt;
      case (state)
        ST_ON: begin
          if (active) begin
            // A request on the threshold cycle wins: the channel stays ON.
            idle_cnt_nxt = '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state_nxt    = ST_OFF;
            idle_cnt_nxt = '0;
          end else begin
            idle_cnt_nxt = idle_cnt + 1'b1;
          end
        end
        ST_OFF: begin
          if (active) begin
            wake_cnt_nxt = '0;
            state_nxt    = (WAKE_CYCLES == 0) ? ST_ON : ST_WAKE;
          end
        end
        ST_WAKE: begin
          // A wake always runs to completion, even if the request drops.
          wake_cnt_nxt = wake_cnt + 1'b1;
          if (wake_cnt == WAKE_LAST) begin
            state_nxt = ST_ON;
          end
        end
        default: begin
          state_nxt    = ST_ON;
          idle_cnt_nxt = '0;
          wake_cnt_nxt = '0;
        end
      endcase
    end

    assign en[g]       = (state != ST_OFF);
    assign on_ready[g] = (state == ST_ON);
  end

  // Enable is re-timed on the falling edge so it only moves while clk is low;
  // the AND below therefore never produces a pulse shorter than clk high time.
  always_ff @(negedge clk) begin
    if (rst) begin
      en_q <= '1;
    end else begin
      en_q <= en;
    end
  end

  assign clk_gated = {NUM_CH{clk}} & (en_q | {NUM_CH{gate_bypass}});
  assign ch_ready  = on_ready | {NUM_CH{gate_bypass}};
  assign ch_on     = en;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb/tb_clk_gate_ctrl.sv - self-checking bench for clk_gate_ctrl
module tb_clk_gate_ctrl;

  localparam int  NUM_CH      = 4;
  localparam int  IDLE_CYCLES = 8;
  localparam int  WAKE_CYCLES = 2;
  localparam time HALF        = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] ch_busy = '0;
  logic [NUM_CH-1:0] force_on = '0;
  logic              gate_bypass = 1'b0;
  logic [NUM_CH-1:0] clk_gated;
  logic [NUM_CH-1:0] ch_ready;
  logic [NUM_CH-1:0] ch_on;

  int checks = 0;
  int errors = 0;
  bit chk_gate = 1'b0;

  clk_gate_ctrl #(
    .NUM_CH(NUM_CH),
    .IDLE_CYCLES(IDLE_CYCLES),
    .WAKE_CYCLES(WAKE_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ch_busy(ch_busy),
    .force_on(force_on),
    .gate_bypass(gate_bypass),
    .clk_gated(clk_gated),
    .ch_ready(ch_ready),
    .ch_on(ch_on)
  );

  always #HALF clk = ~clk;

  // Pulse-width monitor: every gated high pulse must be exactly one clk high phase.
  time t_rise    [NUM_CH];
  int  bad_pulse [NUM_CH];
  int  edges0 = 0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_mon
    initial begin
      t_rise[g]    = 0;
      bad_pulse[g] = 0;
    end
    always @(posedge clk_gated[g]) t_rise[g] = $time;
    always @(negedge clk_gated[g]) begin
      if (chk_gate && ($time - t_rise[g]) != HALF) bad_pulse[g] = bad_pulse[g] + 1;
    end
  end

  always @(posedge clk_gated[0]) edges0 = edges0 + 1;

  // Reference model: each channel is either off, waking with some cycles left,
  // or on with a run length of consecutive idle cycles.
  bit m_off       [NUM_CH];
  int m_wake_left [NUM_CH];
  int m_idle_run  [NUM_CH];

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      m_off[i]       = 1'b0;
      m_wake_left[i] = 0;
      m_idle_run[i]  = 0;
    end
  end

  function automatic logic [NUM_CH-1:0] m_en();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = !m_off[i];
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] m_ready();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = !m_off[i] && (m_wake_left[i] == 0);
    return v;
  endfunction

  task automatic m_step(input logic [NUM_CH-1:0] b, input logic [NUM_CH-1:0] f, input logic r);
    for (int i = 0; i < NUM_CH; i++) begin
      if (r) begin
        m_off[i] = 1'b0;
        m_wake_left[i] = 0;
        m_idle_run[i] = 0;
      end else if (m_off[i]) begin
        if (b[i] || f[i]) begin
          m_off[i] = 1'b0;
          m_wake_left[i] = WAKE_CYCLES;
          m_idle_run[i] = 0;
        end
      end else if (m_wake_left[i] > 0) begin
        m_wake_left[i] = m_wake_left[i] - 1;
      end else if (b[i] || f[i]) begin
        m_idle_run[i] = 0;
      end else begin
        m_idle_run[i] = m_idle_run[i] + 1;
        if (m_idle_run[i] == IDLE_CYCLES) begin
          m_off[i] = 1'b1;
          m_idle_run[i] = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs in the low phase, check combinational ready,
  // advance the model at posedge, check the high phase and the next low phase.
  task automatic cyc(input logic [NUM_CH-1:0] b, input logic [NUM_CH-1:0] f,
                     input logic byp, input logic r);
    logic [NUM_CH-1:0] en_before;
    ch_busy = b;
    force_on = f;
    gate_bypass = byp;
    rst = r;
    #1;
    if (chk_gate) check("ready_comb", 32'(ch_ready), 32'(m_ready() | {NUM_CH{byp}}));
    @(posedge clk);
    en_before = m_en();
    m_step(b, f, r);
    #1;
    if (chk_gate) check("gated_high", 32'(clk_gated), 32'(en_before | {NUM_CH{byp}}));
    check("ch_on", 32'(ch_on), 32'(m_en()));
    check("ch_ready", 32'(ch_ready), 32'(m_ready() | {NUM_CH{byp}}));
    @(negedge clk);
    #1;
    if (chk_gate) check("gated_low", 32'(clk_gated), 32'd0);
  endtask

  initial begin
    int e0;
    logic [NUM_CH-1:0] rb;
    logic [NUM_CH-1:0] rf;
    logic rbyp;
    logic rr;

    // Reset
    cyc('0, '0, 1'b0, 1'b1);
    check("reset_on", 32'(ch_on), 32'hF);
    check("reset_ready", 32'(ch_ready), 32'hF);
    chk_gate = 1'b1;
    cyc('0, '0, 1'b0, 1'b1);
    cyc('0, '0, 1'b0, 1'b1);

    // Idle after reset: exactly IDLE_CYCLES gated edges on ch0, then everything off
    e0 = edges0;
    repeat (20) cyc('0, '0, 1'b0, 1'b0);
    check("ch0_edges_after_rst", 32'(edges0 - e0), 32'd8);
    check("all_off", 32'(ch_on), 32'h0);
    check("all_not_ready", 32'(ch_ready), 32'h0);

    // One-cycle busy pulse on ch1 wakes it with 2-cycle latency, then re-gates
    cyc(4'b0010, '0, 1'b0, 1'b0);
    check("ch1_wake_on", 32'(ch_on[1]), 32'd1);
    check("ch1_wake_not_ready0", 32'(ch_ready[1]), 32'd0);
    cyc('0, '0, 1'b0, 1'b0);
    check("ch1_wake_not_ready1", 32'(ch_ready[1]), 32'd0);
    cyc('0, '0, 1'b0, 1'b0);
    check("ch1_ready", 32'(ch_ready[1]), 32'd1);
    repeat (7) cyc('0, '0, 1'b0, 1'b0);
    check("ch1_still_on", 32'(ch_on[1]), 32'd1);
    cyc('0, '0, 1'b0, 1'b0);
    check("ch1_regated", 32'(ch_on[1]), 32'd0);

    // ch2: idle runs of 7 never gate; a run of 8 does
    repeat (3) begin
      cyc(4'b0100, '0, 1'b0, 1'b0);
      repeat (7) cyc('0, '0, 1'b0, 1'b0);
      check("ch2_run7_on", 32'(ch_on[2]), 32'd1);
    end
    cyc(4'b0100, '0, 1'b0, 1'b0);
    repeat (8) cyc('0, '0, 1'b0, 1'b0);
    check("ch2_run8_off", 32'(ch_on[2]), 32'd0);

    // force_on holds ch3 on for 100 cycles, release gates after 8 idle
    repeat (100) cyc('0, 4'b1000, 1'b0, 1'b0);
    check("ch3_forced_ready", 32'(ch_ready[3]), 32'd1);
    repeat (7) cyc('0, '0, 1'b0, 1'b0);
    check("ch3_release_on", 32'(ch_on[3]), 32'd1);
    cyc('0, '0, 1'b0, 1'b0);
    check("ch3_release_off", 32'(ch_on[3]), 32'd0);

    // Bypass while all channels are off
    repeat (5) cyc('0, '0, 1'b1, 1'b0);
    check("bypass_ready", 32'(ch_ready), 32'hF);
    check("bypass_fsm_off", 32'(ch_on), 32'h0);
    repeat (3) cyc('0, '0, 1'b0, 1'b0);
    check("unbypass_ready", 32'(ch_ready), 32'h0);

    // Reset in the middle of a wake
    cyc(4'hF, '0, 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0);
    check("midwake_not_ready", 32'(ch_ready), 32'h0);
    cyc('0, '0, 1'b0, 1'b1);
    check("midwake_rst_ready", 32'(ch_ready), 32'hF);
    check("midwake_rst_on", 32'(ch_on), 32'hF);
    repeat (3) cyc('0, '0, 1'b0, 1'b0);

    // Randomized traffic against the model
    repeat (400) begin
      rb   = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0;
      rf   = ($urandom_range(0, 15) == 0) ? NUM_CH'($urandom) : '0;
      rbyp = ($urandom_range(0, 19) == 0);
      rr   = ($urandom_range(0, 99) == 0);
      cyc(rb, rf, rbyp, rr);
    end

    for (int i = 0; i < NUM_CH; i++) check($sformatf("pulse_width_ch%0d", i), 32'(bad_pulse[i]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
